// File: rtl/riscv_icache_arb.sv
// Two-requester arbiter sharing one icache port, with at most one fetch outstanding.
// Define RISCV_ICACHE_ARB_FIXED_PRIO_EN to make requester 0 win every tie (default: round-robin).
module riscv_icache_arb (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_rd_i,
  input  logic [31:0] req0_pc_i,
  input  logic [1:0]  req0_priv_i,
  input  logic        req0_flush_i,
  input  logic        req1_rd_i,
  input  logic [31:0] req1_pc_i,
  input  logic [1:0]  req1_priv_i,
  input  logic        req1_flush_i,
  output logic        req0_accept_o,
  output logic        req0_valid_o,
  output logic [31:0] req0_inst_o,
  output logic        req0_error_o,
  output logic        req0_page_fault_o,
  output logic        req1_accept_o,
  output logic        req1_valid_o,
  output logic [31:0] req1_inst_o,
  output logic        req1_error_o,
  output logic        req1_page_fault_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic        icache_flush_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i
);

  typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_t;

  state_t r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_flush_pend, w_flush_pend_nxt;
  logic   r_hold, w_hold_nxt;
  logic   r_hold_gnt;
  logic   w_flush_any, w_rsp, w_flush_issue, w_arb_active;
  logic   w_grant, w_gnt_rd, w_rd, w_accept, w_tie_gnt;

`ifdef RISCV_ICACHE_ARB_FIXED_PRIO_EN
  assign w_tie_gnt = 1'b0;
`else
  logic r_last;

  assign w_tie_gnt = ~r_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant;
    end
  end
`endif

  always_comb begin
    w_flush_any   = req0_flush_i | req1_flush_i;
    w_rsp         = (r_state == StBusy) & icache_valid_i;
    w_flush_issue = r_flush_pend & (r_state == StIdle);
    // Any flush, pending or just arriving, blocks new grants so it reaches the cache first.
    w_arb_active  = ((r_state == StIdle) | w_rsp) & ~r_flush_pend & ~w_flush_any;

    if (r_hold && (r_hold_gnt ? req1_rd_i : req0_rd_i)) begin
      w_grant = r_hold_gnt;
    end else if (req0_rd_i && req1_rd_i) begin
      w_grant = w_tie_gnt;
    end else begin
      w_grant = req1_rd_i;
    end

    w_gnt_rd = w_grant ? req1_rd_i : req0_rd_i;
    w_rd     = w_arb_active & w_gnt_rd;
    w_accept = w_rd & icache_accept_i;

    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StBusy;
      StBusy:  if (w_rsp && !w_accept) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase

    w_owner_nxt = w_accept ? w_grant : r_owner;

    // A flush arriving while one is being issued merges into that pulse.
    if (w_flush_issue) begin
      w_flush_pend_nxt = 1'b0;
    end else if (w_flush_any) begin
      w_flush_pend_nxt = 1'b1;
    end else begin
      w_flush_pend_nxt = r_flush_pend;
    end

    w_hold_nxt = w_rd & ~icache_accept_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_hold       <= 1'b0;
      r_hold_gnt   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_gnt   <= w_grant;
    end
  end

  assign icache_rd_o    = w_rd;
  assign icache_pc_o    = w_rd ? (w_grant ? req1_pc_i : req0_pc_i) : 32'h0;
  assign icache_priv_o  = w_rd ? (w_grant ? req1_priv_i : req0_priv_i) : 2'b00;
  assign icache_flush_o = w_flush_issue;

  assign req0_accept_o = w_accept & ~w_grant;
  assign req1_accept_o = w_accept & w_grant;

  assign req0_valid_o = w_rsp & ~r_owner;
  assign req1_valid_o = w_rsp & r_owner;

  assign req0_inst_o       = w_rsp ? icache_inst_i : 32'h0;
  assign req1_inst_o       = w_rsp ? icache_inst_i : 32'h0;
  assign req0_error_o      = w_rsp & icache_error_i;
  assign req1_error_o      = w_rsp & icache_error_i;
  assign req0_page_fault_o = w_rsp & icache_page_fault_i;
  assign req1_page_fault_o = w_rsp & icache_page_fault_i;

endmodule

// File: tb/tb_riscv_icache_arb.sv
// Directed self-checking bench for riscv_icache_arb; inputs change on the falling edge.
module tb_riscv_icache_arb;

`ifdef RISCV_ICACHE_ARB_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_rd, req0_flush, req1_rd, req1_flush;
  logic [31:0] req0_pc, req1_pc;
  logic [1:0]  req0_priv, req1_priv;
  logic        req0_accept, req0_valid, req0_error, req0_pf;
  logic        req1_accept, req1_valid, req1_error, req1_pf;
  logic [31:0] req0_inst, req1_inst;
  logic        icache_rd, icache_flush;
  logic [31:0] icache_pc;
  logic [1:0]  icache_priv;
  logic        icache_accept, icache_valid, icache_error, icache_pf;
  logic [31:0] icache_inst;

  int n_checks = 0;
  int n_errors = 0;
  logic g, prev;

  always #5 clk = ~clk;

  riscv_icache_arb u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req0_rd_i          (req0_rd),
    .req0_pc_i          (req0_pc),
    .req0_priv_i        (req0_priv),
    .req0_flush_i       (req0_flush),
    .req1_rd_i          (req1_rd),
    .req1_pc_i          (req1_pc),
    .req1_priv_i        (req1_priv),
    .req1_flush_i       (req1_flush),
    .req0_accept_o      (req0_accept),
    .req0_valid_o       (req0_valid),
    .req0_inst_o        (req0_inst),
    .req0_error_o       (req0_error),
    .req0_page_fault_o  (req0_pf),
    .req1_accept_o      (req1_accept),
    .req1_valid_o       (req1_valid),
    .req1_inst_o        (req1_inst),
    .req1_error_o       (req1_error),
    .req1_page_fault_o  (req1_pf),
    .icache_rd_o        (icache_rd),
    .icache_pc_o        (icache_pc),
    .icache_priv_o      (icache_priv),
    .icache_flush_o     (icache_flush),
    .icache_accept_i    (icache_accept),
    .icache_valid_i     (icache_valid),
    .icache_inst_i      (icache_inst),
    .icache_error_i     (icache_error),
    .icache_page_fault_i(icache_pf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clr();
    req0_rd = 0; req0_flush = 0; req0_pc = 0; req0_priv = 0;
    req1_rd = 0; req1_flush = 0; req1_pc = 0; req1_priv = 0;
    icache_accept = 0; icache_valid = 0; icache_inst = 0; icache_error = 0; icache_pf = 0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk); #1;
    check("rst_rd", 32'(icache_rd), 0);
    check("rst_flush", 32'(icache_flush), 0);
    check("rst_v0", 32'(req0_valid), 0);
    check("rst_v1", 32'(req1_valid), 0);
    @(negedge clk); rst = 1'b0;

    // Spurious response in IDLE
    icache_valid = 1; icache_inst = 32'hDEAD_BEEF; #1;
    check("spur_v0", 32'(req0_valid), 0);
    check("spur_v1", 32'(req1_valid), 0);
    check("spur_inst", req0_inst, 0);

    // Both requesting: grants alternate (round-robin) or stay on 0 (fixed priority)
    @(negedge clk); clr();
    req0_rd = 1; req1_rd = 1; req0_pc = 32'h100; req1_pc = 32'h200;
    req0_priv = 2'd3; req1_priv = 2'd1; icache_accept = 1;
    prev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin req0_rd = 0; req1_rd = 0; end
      #1;
      if (k > 0) begin
        check("rr_v0", 32'(req0_valid), 32'(prev == 1'b0));
        check("rr_v1", 32'(req1_valid), 32'(prev == 1'b1));
        check("rr_inst", req1_inst, 32'h1000 + k);
      end
      if (k == 4) begin
        check("rr_end_rd", 32'(icache_rd), 0);
        break;
      end
      g = (Fixed || (k % 2 == 0)) ? 1'b0 : 1'b1;
      check("rr_rd", 32'(icache_rd), 1);
      check("rr_pc", icache_pc, g ? 32'h200 : 32'h100);
      check("rr_priv", 32'(icache_priv), g ? 1 : 3);
      check("rr_acc0", 32'(req0_accept), 32'(!g));
      check("rr_acc1", 32'(req1_accept), 32'(g));
      prev = g;
      @(negedge clk); icache_valid = 0; #1;
      check("rr_busy", 32'(icache_rd), 0);
      @(negedge clk); icache_valid = 1; icache_inst = 32'h1000 + k + 1;
    end

    // Unaccepted request holds its grant even when the other requester joins
    @(negedge clk); clr();
    req1_rd = 1; req1_pc = 32'h300; req1_priv = 2'd2; #1;
    check("hold_rd", 32'(icache_rd), 1);
    check("hold_pc_a", icache_pc, 32'h300);
    check("hold_acc1_a", 32'(req1_accept), 0);
    @(negedge clk); req0_rd = 1; req0_pc = 32'h400; #1;
    check("hold_pc_b", icache_pc, 32'h300);
    check("hold_acc0_b", 32'(req0_accept), 0);
    @(negedge clk); #1;
    check("hold_pc_c", icache_pc, 32'h300);
    check("hold_acc1_c", 32'(req1_accept), 0);
    @(negedge clk); icache_accept = 1; #1;
    check("hold_acc1_d", 32'(req1_accept), 1);
    check("hold_acc0_d", 32'(req0_accept), 0);
    check("hold_priv", 32'(icache_priv), 2);

    // Response and new accept in the same cycle
    @(negedge clk); req1_rd = 0; #1;
    check("b2b_busy", 32'(icache_rd), 0);
    @(negedge clk); icache_valid = 1; icache_inst = 32'h5555_0000; icache_error = 1; #1;
    check("b2b_v1", 32'(req1_valid), 1);
    check("b2b_v0", 32'(req0_valid), 0);
    check("b2b_acc0", 32'(req0_accept), 1);
    check("b2b_pc", icache_pc, 32'h400);
    check("b2b_err1", 32'(req1_error), 1);
    @(negedge clk); icache_valid = 0; icache_error = 0; #1;
    check("b2b_still_busy", 32'(icache_rd), 0);
    @(negedge clk); req0_rd = 0; icache_valid = 1; #1;
    check("b2b_v0_rsp", 32'(req0_valid), 1);
    check("b2b_v1_rsp", 32'(req1_valid), 0);

    // Flush raised while BUSY waits for the response
    @(negedge clk); icache_valid = 0; req0_rd = 1; req0_pc = 32'h500; #1;
    check("fb_acc0", 32'(req0_accept), 1);
    @(negedge clk); req0_rd = 0; req0_flush = 1; #1;
    check("fb_flush_a", 32'(icache_flush), 0);
    @(negedge clk); req0_flush = 0; #1;
    check("fb_flush_b", 32'(icache_flush), 0);
    @(negedge clk); icache_valid = 1; req1_rd = 1; req1_pc = 32'h600; #1;
    check("fb_v0", 32'(req0_valid), 1);
    check("fb_rd_blocked", 32'(icache_rd), 0);
    check("fb_flush_c", 32'(icache_flush), 0);
    @(negedge clk); icache_valid = 0; #1;
    check("fb_flush_pulse", 32'(icache_flush), 1);
    check("fb_rd_nogrant", 32'(icache_rd), 0);
    check("fb_acc1_nogrant", 32'(req1_accept), 0);
    @(negedge clk); #1;
    check("fb_flush_single", 32'(icache_flush), 0);
    check("fb_acc1", 32'(req1_accept), 1);
    check("fb_pc", icache_pc, 32'h600);
    @(negedge clk); req1_rd = 0; icache_valid = 1; #1;
    check("fb_v1", 32'(req1_valid), 1);

    // Flush and rd in the same IDLE cycle: flush goes first
    @(negedge clk); icache_valid = 0; req0_rd = 1; req0_pc = 32'h700; req1_flush = 1; #1;
    check("fi_rd_a", 32'(icache_rd), 0);
    check("fi_flush_a", 32'(icache_flush), 0);
    @(negedge clk); req1_flush = 0; #1;
    check("fi_flush_b", 32'(icache_flush), 1);
    check("fi_rd_b", 32'(icache_rd), 0);
    @(negedge clk); #1;
    check("fi_flush_c", 32'(icache_flush), 0);
    check("fi_acc0", 32'(req0_accept), 1);
    check("fi_pc", icache_pc, 32'h700);
    @(negedge clk); req0_rd = 0; icache_valid = 1; #1;
    check("fi_v0", 32'(req0_valid), 1);

    // Reset while BUSY drops the late response and restores tie order
    @(negedge clk); icache_valid = 0; req1_rd = 1; req1_pc = 32'h800; #1;
    check("rb_acc1", 32'(req1_accept), 1);
    @(negedge clk); req1_rd = 0; rst = 1; #1;
    check("rb_rd", 32'(icache_rd), 0);
    check("rb_flush", 32'(icache_flush), 0);
    @(negedge clk); rst = 0; icache_valid = 1; icache_inst = 32'h1234; #1;
    check("rb_v1", 32'(req1_valid), 0);
    check("rb_v0", 32'(req0_valid), 0);
    check("rb_inst", req1_inst, 0);
    @(negedge clk); icache_valid = 0; req0_rd = 1; req1_rd = 1;
    req0_pc = 32'h900; req1_pc = 32'hA00; #1;
    check("rb_tie_acc0", 32'(req0_accept), 1);
    check("rb_tie_acc1", 32'(req1_accept), 0);
    check("rb_tie_pc", icache_pc, 32'h900);
    @(negedge clk); icache_valid = 1; #1;
    g = Fixed ? 1'b0 : 1'b1;
    check("rb_v0_after", 32'(req0_valid), 1);
    check("rb_tie2_acc1", 32'(req1_accept), 32'(g));
    check("rb_tie2_pc", icache_pc, g ? 32'hA00 : 32'h900);
    @(negedge clk); clr();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
